// File: rtl/ddr4_mult_bank_access_controller_if.sv
// Host-side request/response bundle for the DDR4 multi-bank access controller.
// The host (master) drives requests; the controller (slave) returns read data and completion.
interface ddr4_mult_bank_access_controller_if;
  logic [31:0] addr;
  logic [15:0] wdata;
  logic [1:0]  bg_en;
  logic        read_en;
  logic        write_en;
  logic [15:0] rdata;
  logic        ready;

  modport master (output addr, wdata, bg_en, read_en, write_en, input rdata, ready);
  modport slave  (input addr, wdata, bg_en, read_en, write_en, output rdata, ready);
endinterface

// File: rtl/ddr4_mult_bank_access_controller.sv
// Single-beat DDR4 command sequencer: keeps one open row per bank (4 groups x 8 banks)
// and turns host reads/writes into ACT / RD / WR / PRE sequences with registered pins.
module ddr4_mult_bank_access_controller (
  input  logic       clk,
  input  logic       rst_n,
  ddr4_mult_bank_access_controller_if.slave host,
  inout  wire [15:0] ddr4_dq,
  output logic [15:0] ddr4_addr,
  output logic [2:0]  ddr4_ba,
  output logic [1:0]  ddr4_bg,
  output logic        ddr4_ras_n,
  output logic        ddr4_cas_n,
  output logic        ddr4_we_n,
  output logic        ddr4_cs_n
);

  localparam int TRCD = 3;
  localparam int TRP  = 3;
  localparam int CL   = 4;
  localparam int CWL  = 3;

  // Wait counters count down to zero; the command cycle itself covers one cycle of each delay.
  localparam logic [2:0] TRP_LOAD  = 3'(TRP - 2);
  localparam logic [2:0] TRCD_LOAD = 3'(TRCD - 2);
  localparam logic [2:0] CL_LOAD   = 3'(CL - 2);
  localparam logic [2:0] CWL_LOAD  = 3'(CWL - 2);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_PRE       = 4'd1;
  localparam logic [3:0] S_TRP_WAIT  = 4'd2;
  localparam logic [3:0] S_ACT       = 4'd3;
  localparam logic [3:0] S_TRCD_WAIT = 4'd4;
  localparam logic [3:0] S_RD        = 4'd5;
  localparam logic [3:0] S_WR        = 4'd6;
  localparam logic [3:0] S_CAS_WAIT  = 4'd7;
  localparam logic [3:0] S_DATA      = 4'd8;
  localparam logic [3:0] S_DONE      = 4'd9;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_DES = 4'b1111;
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  logic [3:0]  state;
  logic [2:0]  wait_cnt;
  logic        is_wr;
  logic [4:0]  req_idx;
  logic [15:0] req_row;
  logic [9:0]  req_col;
  logic [15:0] req_wdata;
  logic [31:0] row_valid;
  logic [15:0] open_row [32];
  logic [3:0]  cmd_next;
  logic        dq_oe;
  logic [15:0] dq_out;

  logic [4:0]  in_idx;
  logic [15:0] in_row;
  logic        in_req;
  logic        unused_addr_hi;

  assign in_idx         = {host.bg_en, host.addr[12:10]};
  assign in_row         = host.addr[28:13];
  assign in_req         = host.read_en | host.write_en;
  assign unused_addr_hi = &host.addr[31:29];

  assign ddr4_dq = dq_oe ? dq_out : 16'hzzzz;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      is_wr     <= 1'b0;
      req_idx   <= '0;
      req_row   <= '0;
      req_col   <= '0;
      req_wdata <= '0;
      row_valid <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_req) begin
            is_wr     <= host.write_en;  // write wins when both are requested
            req_idx   <= in_idx;
            req_row   <= in_row;
            req_col   <= host.addr[9:0];
            req_wdata <= host.wdata;
            if (!row_valid[in_idx])              state <= S_ACT;
            else if (open_row[in_idx] != in_row) state <= S_PRE;
            else                                 state <= host.write_en ? S_WR : S_RD;
          end
        end
        S_PRE: begin
          wait_cnt <= TRP_LOAD;
          state    <= S_TRP_WAIT;
        end
        S_TRP_WAIT: begin
          if (wait_cnt == '0) state <= S_ACT;
          else                wait_cnt <= wait_cnt - 3'd1;
        end
        S_ACT: begin
          row_valid[req_idx] <= 1'b1;
          wait_cnt <= TRCD_LOAD;
          state    <= S_TRCD_WAIT;
        end
        S_TRCD_WAIT: begin
          if (wait_cnt == '0) state <= is_wr ? S_WR : S_RD;
          else                wait_cnt <= wait_cnt - 3'd1;
        end
        S_RD: begin
          wait_cnt <= CL_LOAD;
          state    <= S_CAS_WAIT;
        end
        S_WR: begin
          wait_cnt <= CWL_LOAD;
          state    <= S_CAS_WAIT;
        end
        S_CAS_WAIT: begin
          if (wait_cnt == '0) state <= S_DATA;
          else                wait_cnt <= wait_cnt - 3'd1;
        end
        S_DATA:  state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the row storage has no reset; only the valid bits are cleared, which is all that matters.
  always_ff @(posedge clk) begin
    if (state == S_ACT) open_row[req_idx] <= req_row;
  end

  // NOTE: default assignment first so no path leaves cmd_next unassigned (no latch).
  always_comb begin
    cmd_next = CMD_NOP;
    case (state)
      S_IDLE:  cmd_next = CMD_DES;
      S_PRE:   cmd_next = CMD_PRE;
      S_ACT:   cmd_next = CMD_ACT;
      S_RD:    cmd_next = CMD_RD;
      S_WR:    cmd_next = CMD_WR;
      default: cmd_next = CMD_NOP;
    endcase
  end

  // Pins are registered from the state, so each command appears one cycle after its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {ddr4_cs_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n} <= CMD_DES;
      ddr4_addr  <= '0;
      ddr4_ba    <= '0;
      ddr4_bg    <= '0;
      dq_oe      <= 1'b0;
      dq_out     <= '0;
      host.ready <= 1'b0;
      host.rdata <= '0;
    end else begin
      {ddr4_cs_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n} <= cmd_next;
      case (state)
        S_PRE: begin
          ddr4_addr          <= '0;  // A10 low: precharge only the target bank
          {ddr4_bg, ddr4_ba} <= req_idx;
        end
        S_ACT: begin
          ddr4_addr          <= req_row;
          {ddr4_bg, ddr4_ba} <= req_idx;
        end
        S_RD, S_WR: begin
          ddr4_addr          <= {6'b0, req_col};
          {ddr4_bg, ddr4_ba} <= req_idx;
        end
        default: ;
      endcase
      dq_oe      <= (state == S_DATA) && is_wr;
      dq_out     <= req_wdata;
      host.ready <= (state == S_DONE);
      if ((state == S_DONE) && !is_wr) host.rdata <= ddr4_dq;
    end
  end

endmodule

// File: tb/tb_ddr4_mult_bank_access_controller.sv
// Randomized scoreboard bench: a transaction-level model predicts pin events, a monitor compares them.
module tb_ddr4_mult_bank_access_controller;
  localparam int TRCD = 3;
  localparam int TRP  = 3;
  localparam int CL   = 4;
  localparam int CWL  = 3;
  localparam int EV_CMD = 0;
  localparam int EV_WDQ = 1;
  localparam int EV_RDY = 2;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;

  typedef struct {
    int          kind;
    int          cyc;
    logic [3:0]  cmd;
    logic [15:0] a;
    logic [2:0]  ba;
    logic [1:0]  bg;
    logic [15:0] d;
  } ev_t;

  typedef struct {
    int        cyc;
    bit [30:0] key;
  } dev_op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr4_mult_bank_access_controller_if host_if();
  wire  [15:0] ddr4_dq;
  logic [15:0] ddr4_addr;
  logic [2:0]  ddr4_ba;
  logic [1:0]  ddr4_bg;
  logic        ddr4_ras_n, ddr4_cas_n, ddr4_we_n, ddr4_cs_n;
  logic [15:0] dev_dq = '0;
  logic        dev_oe = 1'b0;

  assign ddr4_dq = dev_oe ? dev_dq : 16'hzzzz;

  ddr4_mult_bank_access_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .host      (host_if),
    .ddr4_dq   (ddr4_dq),
    .ddr4_addr (ddr4_addr),
    .ddr4_ba   (ddr4_ba),
    .ddr4_bg   (ddr4_bg),
    .ddr4_ras_n(ddr4_ras_n),
    .ddr4_cas_n(ddr4_cas_n),
    .ddr4_we_n (ddr4_we_n),
    .ddr4_cs_n (ddr4_cs_n)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  ev_t exp_q[$];
  logic [15:0] ref_open [int];
  logic [15:0] ref_mem [bit [30:0]];
  logic [15:0] ref_last = '0;
  logic [15:0] dev_row [32];
  logic [15:0] dev_mem [bit [30:0]];
  dev_op_t rd_q[$];
  dev_op_t wr_q[$];

  function automatic logic [15:0] init_word(bit [30:0] k);
    return k[15:0] ^ 16'h5C3A;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: open-row bookkeeping and latency arithmetic taken straight from the timing rules.
  task automatic model(bit wr, logic [1:0] bg, logic [31:0] a, logic [15:0] wd, int t0);
    logic [2:0]  ba  = a[12:10];
    logic [15:0] row = a[28:13];
    logic [9:0]  col = a[9:0];
    int          idx = int'({bg, ba});
    int          c   = t0 + 1;
    bit [30:0]   key = {bg, ba, row, col};
    logic [15:0] d;
    if (ref_open.exists(idx) && ref_open[idx] != row) begin
      exp_q.push_back('{EV_CMD, c, C_PRE, 16'h0, ba, bg, 16'h0});
      c += TRP;
    end
    if (!ref_open.exists(idx) || ref_open[idx] != row) begin
      exp_q.push_back('{EV_CMD, c, C_ACT, row, ba, bg, 16'h0});
      ref_open[idx] = row;
      c += TRCD;
    end
    if (wr) begin
      exp_q.push_back('{EV_CMD, c, C_WR, {6'b0, col}, ba, bg, 16'h0});
      exp_q.push_back('{EV_WDQ, c + CWL, 4'h0, 16'h0, 3'h0, 2'h0, wd});
      exp_q.push_back('{EV_RDY, c + CWL + 1, 4'h0, 16'h0, 3'h0, 2'h0, ref_last});
      ref_mem[key] = wd;
    end else begin
      d = ref_mem.exists(key) ? ref_mem[key] : init_word(key);
      ref_last = d;
      exp_q.push_back('{EV_CMD, c, C_RD, {6'b0, col}, ba, bg, 16'h0});
      exp_q.push_back('{EV_RDY, c + CL + 1, 4'h0, 16'h0, 3'h0, 2'h0, d});
    end
  endtask

  task automatic issue(bit wr, bit rd, logic [1:0] bg, logic [31:0] a, logic [15:0] wd, int gap);
    int n;
    if (gap > 0) begin
      host_if.write_en = 1'b0;
      host_if.read_en  = 1'b0;
      repeat (gap) @(negedge clk);
    end
    host_if.addr     = a;
    host_if.bg_en    = bg;
    host_if.wdata    = wd;
    host_if.write_en = wr;
    host_if.read_en  = rd;
    model(wr, bg, a, wd, cyc + 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!host_if.ready && n < 40);
    if (!host_if.ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic observe(int kind, logic [3:0] cmd, logic [15:0] a, logic [2:0] ba,
                         logic [1:0] bg, logic [15:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", kind, 32'hFF);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", kind, e.kind);
    check("event_cycle", cyc, e.cyc);
    if (kind == EV_CMD) begin
      check("cmd_pins", cmd, e.cmd);
      if (e.cmd == C_PRE) check("pre_a10", a[10], e.a[10]);
      else                check("cmd_addr", a, e.a);
      check("cmd_ba", ba, e.ba);
      check("cmd_bg", bg, e.bg);
    end else if (kind == EV_WDQ) begin
      check("write_dq", d, e.d);
    end else begin
      check("rdata", d, e.d);
    end
  endtask

  // Monitor: any command, DUT-driven data beat or ready pulse is matched against the queue head.
  always @(negedge clk) begin
    logic [3:0] cmd;
    cmd = {ddr4_cs_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n};
    if (rst_n) begin
      if (cmd != 4'b1111 && cmd != 4'b0111) observe(EV_CMD, cmd, ddr4_addr, ddr4_ba, ddr4_bg, 16'h0);
      if (!dev_oe && ddr4_dq !== 16'hzzzz) observe(EV_WDQ, 4'h0, 16'h0, 3'h0, 2'h0, ddr4_dq);
      if (host_if.ready) observe(EV_RDY, 4'h0, 16'h0, 3'h0, 2'h0, host_if.rdata);
    end
  end

  // Device model: tracks rows from ACT, captures writes CWL after WR, returns reads CL after RD.
  always @(negedge clk) begin
    logic [3:0] cmd;
    logic [4:0] bi;
    cmd = {ddr4_cs_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n};
    bi  = {ddr4_bg, ddr4_ba};
    if (!rst_n) begin
      rd_q.delete();
      wr_q.delete();
      dev_oe <= 1'b0;
    end else begin
      dev_oe <= 1'b0;
      if (cmd == C_ACT) dev_row[bi] = ddr4_addr;
      if (cmd == C_RD)  rd_q.push_back('{cyc + CL, {bi, dev_row[bi], ddr4_addr[9:0]}});
      if (cmd == C_WR)  wr_q.push_back('{cyc + CWL, {bi, dev_row[bi], ddr4_addr[9:0]}});
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        dev_dq <= dev_mem.exists(rd_q[0].key) ? dev_mem[rd_q[0].key] : init_word(rd_q[0].key);
        dev_oe <= 1'b1;
        void'(rd_q.pop_front());
      end
      if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
        dev_mem[wr_q[0].key] = ddr4_dq;
        void'(wr_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  bg;
    int          op;
    host_if.addr     = '0;
    host_if.wdata    = '0;
    host_if.bg_en    = '0;
    host_if.read_en  = 1'b0;
    host_if.write_en = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cmd", {ddr4_cs_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n}, 4'b1111);
    check("reset_ready", host_if.ready, 1'b0);
    check("reset_rdata", host_if.rdata, 16'h0);
    check("reset_dq_z", ddr4_dq === 16'hzzzz, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_deselect", {ddr4_cs_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n}, 4'b1111);

    // Closed write, hit read, miss read/write, and a miss back to the first row.
    issue(1'b1, 1'b0, 2'd2, 32'h0405_0600, 16'hA5A5, 0);
    issue(1'b0, 1'b1, 2'd2, 32'h0405_0600, 16'h0000, 1);
    issue(1'b0, 1'b1, 2'd2, 32'h0405_2600, 16'h0000, 0);
    issue(1'b1, 1'b0, 2'd2, 32'h0405_2600, 16'h5A5A, 0);
    issue(1'b0, 1'b1, 2'd2, 32'h0405_0600, 16'h0000, 2);

    // Same address in two bank groups, then hits in each.
    issue(1'b1, 1'b0, 2'd0, 32'h0405_0600, 16'h1111, 0);
    issue(1'b1, 1'b0, 2'd3, 32'h0405_0600, 16'h3333, 0);
    issue(1'b0, 1'b1, 2'd0, 32'h0405_0600, 16'h0000, 0);
    issue(1'b0, 1'b1, 2'd3, 32'h0405_0600, 16'h0000, 1);

    // Both enables high: the write path is taken.
    issue(1'b1, 1'b1, 2'd1, 32'h1234_5678, 16'hBEEF, 0);
    issue(1'b0, 1'b1, 2'd1, 32'h1234_5678, 16'h0000, 0);

    // Reset while waiting out tRCD on a closed-bank read.
    host_if.addr     = 32'h0000_9C21;
    host_if.bg_en    = 2'd1;
    host_if.read_en  = 1'b1;
    host_if.write_en = 1'b0;
    model(1'b0, 2'd1, 32'h0000_9C21, 16'h0, cyc + 1);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b0;
    host_if.read_en = 1'b0;
    exp_q.delete();
    ref_open.delete();
    ref_last = '0;
    #1;
    check("abort_cmd", {ddr4_cs_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n}, 4'b1111);
    check("abort_addr", ddr4_addr, 16'h0);
    check("abort_ready", host_if.ready, 1'b0);
    check("abort_rdata", host_if.rdata, 16'h0);
    check("abort_dq_z", ddr4_dq === 16'hzzzz, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 1'b1, 2'd1, 32'h0000_9C21, 16'h0000, 0);
    issue(1'b0, 1'b1, 2'd2, 32'h0405_0600, 16'h0000, 0);

    for (int i = 0; i < 60; i++) begin
      bg = 2'($urandom_range(0, 3));
      a  = {3'($urandom), 16'h2028 + 16'($urandom_range(0, 2)), 3'($urandom_range(0, 1)), 10'($urandom)};
      op = int'($urandom_range(0, 2));
      issue(op != 0, op != 1, bg, a, 16'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    host_if.read_en  = 1'b0;
    host_if.write_en = 1'b0;
    repeat (CL + 10) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr4_mult_bank_access_controller.md
# ddr4_mult_bank_access_controller

Single-port DDR4 command controller for a ×16 device that turns simple host read/write requests into ACTIVATE / READ / WRITE / PRECHARGE command sequences. It keeps one row open per bank (4 bank groups × 8 banks) and reuses an open row on a hit. It sits between a host-side request interface and the DDR4 PHY/device pins. Refresh, initialization/MRS and bursts longer than one beat are outside this block's scope.

## Interface
- TRCD, 3, cycles from ACTIVATE to READ/WRITE
- TRP, 3, cycles from PRECHARGE to ACTIVATE
- CL, 4, cycles from READ command to the cycle in which ddr4_dq is sampled
- CWL, 3, cycles from WRITE command to the cycle in which ddr4_dq is driven
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous and active-low
- addr  in  32  host address: col=addr[9:0], bank=addr[12:10], row=addr[28:13], addr[31:29] ignored
- wdata  in  16  write data
- bg_en  in  2  bank group for the request
- read_en  in  1  read request (level)
- write_en  in  1  write request (level)
- rdata  out  16  read data, valid when ready pulses after a read
- ready  out  1  one-cycle completion pulse
- ddr4_dq  inout  16  data bus
- ddr4_addr  out  16  row/column address
- ddr4_ba  out  3  bank address
- ddr4_bg  out  2  bank group
- ddr4_ras_n, ddr4_cas_n, ddr4_we_n, ddr4_cs_n  out  1 each  command pins

## Operation
- Reset (async, rst_n=0): cs_n=ras_n=cas_n=we_n=1, ddr4_addr=0, ba=0, bg=0, rdata=0, ready=0, ddr4_dq=Z, all 32 open-row entries invalid, FSM=IDLE.
- Commands {cs_n,ras_n,cas_n,we_n}: DESELECT 1111, NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010. Each command lasts exactly one cycle. Waits inside a transaction issue NOP. IDLE issues DESELECT.
- Request sampling happens only in IDLE. If both read_en and write_en are high, write wins. Requests are level-sensitive: a request still high in IDLE after ready starts a new transaction. Inputs are latched at acceptance.
- Target bank index = {bg_en, addr[12:10]}. Open-row table holds a valid bit and a 16-bit row per index.
- Hit (valid and row match): RD/WR issued directly.
- Closed (invalid): ACT, then RD/WR.
- Miss (valid, different row): PRE to that bank (ddr4_addr[10]=0), then ACT, then RD/WR. Table updates at ACT.
- Pin values per command:
  - ACT: ddr4_addr=row.
  - RD/WR: ddr4_addr={6'b0,col} (A10=0, no auto-precharge).
  - PRE/ACT/RD/WR: ba/bg = target bank.
- Write data: ddr4_dq=wdata for one cycle, CWL cycles after WR. Z at all other times.
- Read data: ddr4_dq is sampled CL cycles after RD and registered into rdata.
- FSM states and paths: IDLE → (PRE → TRP_WAIT →) (ACT → TRCD_WAIT →) RD|WR → CAS_WAIT → DATA → DONE → IDLE. DONE pulses ready.
- rdata holds its last value across writes and idle.

## Timing
Cycle 0 is the edge where IDLE accepts the request; the first command is on the pins in cycle 1.
- Closed-row write: ACT c1, WR c1+TRCD=4, dq driven c4+CWL=7, ready c8.
- Closed-row read: ACT c1, RD c4, dq sampled c8, rdata valid and ready high c9.
- Hit: RD/WR at c1. Write ready at c5; read ready at c6.
- Miss: PRE c1, ACT c1+TRP=4, RD/WR c7. Everything after that shifts accordingly.
- ready is high for exactly one cycle and is followed by IDLE. The earliest next acceptance is the cycle after ready.
- Reset asserted mid-transaction aborts immediately to the reset state; the open-row table is cleared.

## Test plan
- Reset: hold rst_n=0 → all command pins 1, ready=0, rdata=0, dq=Z. Release → DESELECT until a request arrives.
- Closed-row write: bg_en=2, addr=0x0405_0600, wdata=0xA5A5 → ACT with bg=2, ba=1, ddr4_addr=row 0x2028 at c1; WR with ddr4_addr=0x200 at c4; dq=0xA5A5 at c7; ready at c8.
- Row-hit read at the same address, device model returns 0xA5A5 at the CL cycle → no ACT, RD at c1, rdata=0xA5A5 with ready at c6.
- Row miss: same bank, row+1 → PRE (A10=0) c1, ACT c4 with new row, RD/WR c7.
- Different bank groups: alternate bg_en=0/3 with the same addr → each group opens its own row independently; a later hit in either group skips ACT.
- write_en and read_en both high → write sequence taken. Reset asserted during TRCD_WAIT → pins return to reset values; the next same-row access issues ACT (table cleared).
